// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite encodings and the address-phase record used by the two-master arbiter.
package ahb_arb_pkg;

  // Widest HADDR the address-phase record can carry; ADDR_W must not exceed it.
  localparam int AHB_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_e;

  typedef struct packed {
    logic [AHB_ADDR_MAX_W-1:0] addr;
    htrans_e                   trans;
    logic                      write;
    hsize_e                    size;
    hburst_e                   burst;
    logic [3:0]                prot;
    logic                      lock;
  } ahb_aph_t;

  function automatic logic trans_active(input htrans_e t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-master capture slot: parks an address phase that lost arbitration, raises pend,
// and stalls the master until the parked transfer has finished its slave data phase.
module ahb_arb_hold
  import ahb_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  ahb_aph_t live,
  input  logic     selected,
  input  logic     dph_mine,
  input  logic     s_hready,
  output ahb_aph_t held,
  output logic     pend,
  output logic     m_hready
);

  logic live_req;
  logic drives_live;
  logic capture;
  logic accept;

  always_comb begin
    live_req    = trans_active(live.trans);
    drives_live = selected && !pend && live_req;
    m_hready    = 1'b1;
    // A live transfer on the slave bus must only complete when the slave does,
    // even before this master owns the data phase.
    if (pend) begin
      m_hready = 1'b0;
    end else if (dph_mine || drives_live) begin
      m_hready = s_hready;
    end
    capture = live_req && m_hready && !selected;
    accept  = selected && pend && s_hready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      held <= '0;
    end else if (capture) begin
      pend <= 1'b1;
      held <= live;
    end else if (accept) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter in front of one shared slave; losers are parked, not retried.
// Build option: define AHB_ARB_RR_EN for round-robin tie-break, otherwise M0 wins ties.
module ahb_lite_arb2
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic [3:0]        M0_HPROT,
  input  logic              M0_HLOCK,
  input  logic [31:0]       M0_HWDATA,
  output logic [31:0]       M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic [3:0]        M1_HPROT,
  input  logic              M1_HLOCK,
  input  logic [31:0]       M1_HWDATA,
  output logic [31:0]       M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic              S_HSEL,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [2:0]        S_HBURST,
  output logic [3:0]        S_HPROT,
  output logic              S_HLOCK,
  output logic [31:0]       S_HWDATA,
  input  logic [31:0]       S_HRDATA,
  input  logic              S_HREADY,
  input  logic              S_HRESP
);

  ahb_aph_t live0, live1, held0, held1, own_live, drv;
  logic     pend0, pend1, hready0, hready1;
  logic     req0, req1, keep, s_active, accept;
  logic     dph_vld;
  mst_e     own_q, sel, dph_own, tie_winner;
  logic     addr_unused;

  always_comb begin
    live0 = '{addr: AHB_ADDR_MAX_W'(M0_HADDR), trans: htrans_e'(M0_HTRANS), write: M0_HWRITE,
              size: hsize_e'(M0_HSIZE), burst: hburst_e'(M0_HBURST), prot: M0_HPROT,
              lock: M0_HLOCK};
    live1 = '{addr: AHB_ADDR_MAX_W'(M1_HADDR), trans: htrans_e'(M1_HTRANS), write: M1_HWRITE,
              size: hsize_e'(M1_HSIZE), burst: hburst_e'(M1_HBURST), prot: M1_HPROT,
              lock: M1_HLOCK};
  end

`ifdef AHB_ARB_RR_EN
  mst_e last_grant;

  assign tie_winner = (last_grant == MST_M1) ? MST_M0 : MST_M1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant <= MST_M1;
    end else if (accept) begin
      last_grant <= sel;
    end
  end
`else
  assign tie_winner = MST_M0;
`endif

  // Arbitration: ownership only moves at slave address-phase boundaries, and never
  // out of a burst (SEQ/BUSY) or a locked sequence.
  always_comb begin
    req0     = pend0 || trans_active(live0.trans);
    req1     = pend1 || trans_active(live1.trans);
    own_live = (own_q == MST_M1) ? live1 : live0;
    keep     = (own_live.trans == HTRANS_SEQ) || (own_live.trans == HTRANS_BUSY) ||
               own_live.lock;
    sel      = own_q;
    if (S_HREADY && !keep) begin
      if (req0 && req1) begin
        sel = tie_winner;
      end else if (req0) begin
        sel = MST_M0;
      end else if (req1) begin
        sel = MST_M1;
      end
    end
  end

  always_comb begin
    if (sel == MST_M1) begin
      drv = pend1 ? held1 : live1;
    end else begin
      drv = pend0 ? held0 : live0;
    end
    s_active    = trans_active(drv.trans);
    accept      = S_HREADY && s_active;
    // Bits above ADDR_W are zero-extended and never reach the slave.
    addr_unused = ^drv.addr;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      own_q   <= MST_M0;
      dph_vld <= 1'b0;
      dph_own <= MST_M0;
    end else begin
      own_q <= sel;
      if (S_HREADY) begin
        dph_vld <= accept;
        if (accept) begin
          dph_own <= sel;
        end
      end
    end
  end

  ahb_arb_hold u_hold0 (
    .clk      (CLK),
    .rst      (RESET),
    .live     (live0),
    .selected (sel == MST_M0),
    .dph_mine (dph_vld && (dph_own == MST_M0)),
    .s_hready (S_HREADY),
    .held     (held0),
    .pend     (pend0),
    .m_hready (hready0)
  );

  ahb_arb_hold u_hold1 (
    .clk      (CLK),
    .rst      (RESET),
    .live     (live1),
    .selected (sel == MST_M1),
    .dph_mine (dph_vld && (dph_own == MST_M1)),
    .s_hready (S_HREADY),
    .held     (held1),
    .pend     (pend1),
    .m_hready (hready1)
  );

  // Everything seen by the slave and the masters is parked at its idle value in reset.
  always_comb begin
    S_HSEL    = 1'b0;
    S_HADDR   = '0;
    S_HTRANS  = HTRANS_IDLE;
    S_HWRITE  = 1'b0;
    S_HSIZE   = '0;
    S_HBURST  = '0;
    S_HPROT   = '0;
    S_HLOCK   = 1'b0;
    S_HWDATA  = '0;
    M0_HRDATA = '0;
    M1_HRDATA = '0;
    M0_HREADY = 1'b1;
    M1_HREADY = 1'b1;
    M0_HRESP  = 1'b0;
    M1_HRESP  = 1'b0;
    if (!RESET) begin
      S_HSEL    = s_active;
      S_HADDR   = drv.addr[ADDR_W-1:0];
      S_HTRANS  = drv.trans;
      S_HWRITE  = drv.write;
      S_HSIZE   = drv.size;
      S_HBURST  = drv.burst;
      S_HPROT   = drv.prot;
      S_HLOCK   = drv.lock;
      S_HWDATA  = (dph_own == MST_M1) ? M1_HWDATA : M0_HWDATA;
      M0_HRDATA = S_HRDATA;
      M1_HRDATA = S_HRDATA;
      M0_HREADY = hready0;
      M1_HREADY = hready1;
      M0_HRESP  = dph_vld && (dph_own == MST_M0) && S_HRESP;
      M1_HRESP  = dph_vld && (dph_own == MST_M1) && S_HRESP;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Directed bench for ahb_lite_arb2: single transfer, tie-break, burst lock-out,
// ERROR pass-through and reset with a parked transfer. Follows AHB_ARB_RR_EN if defined.
module tb_ahb_lite_arb2;

`ifdef AHB_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HLOCK, M1_HLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic        S_HSEL, S_HWRITE, S_HLOCK;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT;
  logic        S_HREADY, S_HRESP;

  int n_run  = 0;
  int n_fail = 0;

  ahb_lite_arb2 #(.ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HLOCK(M0_HLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HLOCK(M1_HLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HLOCK(S_HLOCK),
    .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m0_drive(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                          input logic [2:0] bu);
    M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = wr; M0_HBURST = bu;
    M0_HSIZE = 3'd2; M0_HPROT = 4'h3; M0_HLOCK = 1'b0;
  endtask

  task automatic m1_drive(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                          input logic [2:0] bu);
    M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = wr; M1_HBURST = bu;
    M1_HSIZE = 3'd2; M1_HPROT = 4'h3; M1_HLOCK = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic w;
    w = RR;
    RESET = 1'b1;
    m0_drive(2'd0, 32'h0, 1'b0, 3'd0);
    m1_drive(2'd0, 32'h0, 1'b0, 3'd0);
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    S_HRDATA = 32'hDEADBEEF; S_HREADY = 1'b0; S_HRESP = 1'b0;
    step(); step();

    // Reset values
    settle();
    chk("rst_s_htrans", S_HTRANS, 0);
    chk("rst_s_hsel", S_HSEL, 0);
    chk("rst_m0_hready", M0_HREADY, 1);
    chk("rst_m1_hready", M1_HREADY, 1);
    chk("rst_m0_hrdata", M0_HRDATA, 0);
    RESET = 1'b0; S_HREADY = 1'b1;
    settle();
    chk("rdata_bcast_m1", M1_HRDATA, 32'hDEADBEEF);
    step();

    // M0 single write, M1 idle
    m0_drive(2'd2, 32'h8000, 1'b1, 3'd0);
    settle();
    chk("single_haddr", S_HADDR, 32'h8000);
    chk("single_hsel", S_HSEL, 1);
    chk("single_hwrite", S_HWRITE, 1);
    chk("single_m1_hready", M1_HREADY, 1);
    step();
    m0_drive(2'd0, 32'h0, 1'b0, 3'd0);
    M0_HWDATA = 32'h11112222; S_HREADY = 1'b0;
    settle();
    chk("single_m0_wait", M0_HREADY, 0);
    chk("single_hwdata", S_HWDATA, 32'h11112222);
    chk("single_m1_idle_rdy", M1_HREADY, 1);
    chk("single_idle_trans", S_HTRANS, 0);
    step();
    S_HREADY = 1'b1;
    settle();
    chk("single_m0_done", M0_HREADY, 1);
    step();

    // Tie: both NONSEQ; winner is M0 fixed, M1 with round-robin (last grant was M0)
    m0_drive(2'd2, 32'h100, 1'b0, 3'd0);
    m1_drive(2'd2, 32'h200, 1'b1, 3'd0);
    M0_HWDATA = 32'hAAAA0000; M1_HWDATA = 32'hBBBB0000;
    settle();
    chk("tie_win_haddr", S_HADDR, w ? 32'h200 : 32'h100);
    chk("tie_m0_hready", M0_HREADY, 1);
    chk("tie_m1_hready", M1_HREADY, 1);
    step();
    m0_drive(2'd0, 32'h0, 1'b0, 3'd0);
    m1_drive(2'd0, 32'h0, 1'b0, 3'd0);
    settle();
    chk("tie_lose_haddr", S_HADDR, w ? 32'h100 : 32'h200);
    chk("tie_lose_htrans", S_HTRANS, 2);
    chk("tie_lose_hwrite", S_HWRITE, w ? 0 : 1);
    chk("tie_lose_stall", w ? M0_HREADY : M1_HREADY, 0);
    chk("tie_win_done", w ? M1_HREADY : M0_HREADY, 1);
    step();
    S_HREADY = 1'b0;
    settle();
    chk("tie_lose_dph_wait", w ? M0_HREADY : M1_HREADY, 0);
    chk("tie_lose_hwdata", S_HWDATA, w ? 32'hAAAA0000 : 32'hBBBB0000);
    step();
    S_HREADY = 1'b1;
    settle();
    chk("tie_lose_done", w ? M0_HREADY : M1_HREADY, 1);
    chk("tie_bus_idle", S_HTRANS, 0);
    step();

    // M0 INCR4 burst; M1 NONSEQ at beat 2 must wait until the burst ends
    m0_drive(2'd2, 32'h1000, 1'b0, 3'd3);
    settle();
    chk("burst_b1", S_HADDR, 32'h1000);
    step();
    m0_drive(2'd3, 32'h1004, 1'b0, 3'd3);
    m1_drive(2'd2, 32'h3000, 1'b1, 3'd0);
    settle();
    chk("burst_b2", S_HADDR, 32'h1004);
    chk("burst_m1_capt_rdy", M1_HREADY, 1);
    step();
    m0_drive(2'd3, 32'h1008, 1'b0, 3'd3);
    m1_drive(2'd0, 32'h0, 1'b0, 3'd0);
    settle();
    chk("burst_b3", S_HADDR, 32'h1008);
    chk("burst_m1_stall", M1_HREADY, 0);
    step();
    m0_drive(2'd3, 32'h100C, 1'b0, 3'd3);
    settle();
    chk("burst_b4", S_HADDR, 32'h100C);
    chk("burst_b4_trans", S_HTRANS, 3);
    step();
    m0_drive(2'd0, 32'h0, 1'b0, 3'd0);
    settle();
    chk("burst_m1_haddr", S_HADDR, 32'h3000);
    chk("burst_m1_htrans", S_HTRANS, 2);
    chk("burst_m1_hwrite", S_HWRITE, 1);
    step();
    settle();
    chk("burst_m1_done", M1_HREADY, 1);
    step();

    // Two-cycle ERROR on an M1 read
    m1_drive(2'd2, 32'h400, 1'b0, 3'd0);
    settle();
    chk("err_haddr", S_HADDR, 32'h400);
    step();
    m1_drive(2'd0, 32'h0, 1'b0, 3'd0);
    S_HRESP = 1'b1; S_HREADY = 1'b0;
    settle();
    chk("err1_m1_hresp", M1_HRESP, 1);
    chk("err1_m1_hready", M1_HREADY, 0);
    chk("err1_m0_hresp", M0_HRESP, 0);
    step();
    S_HREADY = 1'b1;
    settle();
    chk("err2_m1_hresp", M1_HRESP, 1);
    chk("err2_m1_hready", M1_HREADY, 1);
    chk("err2_m0_hresp", M0_HRESP, 0);
    step();
    S_HRESP = 1'b0;
    settle();
    chk("err_after_m1_hresp", M1_HRESP, 0);
    step();

    // Reset while M1 is parked (M0 wins the tie in both policies here)
    m0_drive(2'd2, 32'h500, 1'b0, 3'd0);
    m1_drive(2'd2, 32'h600, 1'b0, 3'd0);
    settle();
    chk("rstp_win_haddr", S_HADDR, 32'h500);
    step();
    m0_drive(2'd0, 32'h0, 1'b0, 3'd0);
    m1_drive(2'd0, 32'h0, 1'b0, 3'd0);
    RESET = 1'b1;
    settle();
    chk("rstp_during_m1_rdy", M1_HREADY, 1);
    step();
    RESET = 1'b0;
    settle();
    chk("rstp_htrans", S_HTRANS, 0);
    chk("rstp_hsel", S_HSEL, 0);
    chk("rstp_m0_hready", M0_HREADY, 1);
    chk("rstp_m1_hready", M1_HREADY, 1);
    step();
    settle();
    chk("rstp_no_replay", S_HTRANS, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arb2.md
AHB_LITE_ARB2 -- requirements
Module: ahb_lite_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all HADDR ports.
REQ-002 SHALL have one clock and a synchronous, active-high reset: CLK in 1, RESET in 1, both sampled on the rising edge of CLK.
REQ-003 SHALL have M0 address-phase inputs: M0_HADDR in ADDR_W, M0_HTRANS in 2, M0_HWRITE in 1, M0_HSIZE in 3, M0_HBURST in 3, M0_HPROT in 4, M0_HLOCK in 1; M0 is the CPU MEM master.
REQ-004 SHALL have M0 data-phase ports: M0_HWDATA in 32, M0_HRDATA out 32, M0_HREADY out 1, M0_HRESP out 1.
REQ-005 SHALL have M1 ports identical to REQ-003/004 with prefix M1_; M1 is the secondary (DMA/debug) master.
REQ-006 SHALL have slave outputs S_HSEL 1, S_HADDR ADDR_W, S_HTRANS 2, S_HWRITE 1, S_HSIZE 3, S_HBURST 3, S_HPROT 4, S_HLOCK 1, S_HWDATA 32; these drive the shared AHB-Lite slave.
REQ-007 SHALL have slave inputs S_HRDATA 32, S_HREADY 1 (slave HREADYOUT), S_HRESP 1.

Function
REQ-008 SHALL treat a master as requesting when its HTRANS is NONSEQ(2) or SEQ(3), or when its pend flag is set; IDLE/BUSY from a non-owner SHALL be ignored and complete with HREADY=1 and HRESP=0.
REQ-009 SHALL re-arbitrate only on cycles with S_HREADY=1, which are slave address-phase boundaries.
REQ-010 SHALL keep the current address owner through the arbitration point while the owner's live HTRANS is SEQ or BUSY, or while its HLOCK=1; bursts and locked sequences SHALL NOT be interrupted.
REQ-011 SHALL drive the S_ address signals from the owner's hold register when its pend is set, otherwise from the owner's live inputs; S_HSEL=1 only when the driven HTRANS is NONSEQ or SEQ.
REQ-012 SHALL capture a non-owner's address phase into its hold register and set pend when that master presents NONSEQ/SEQ with its HREADY=1 and it is not selected that cycle.
REQ-013 SHALL drive a master's HREADY=0 from the cycle after capture until its captured transfer's data phase completes; pend SHALL clear when the held transfer is accepted by the slave (S_HREADY=1 while driving it).
REQ-014 SHALL register the data-phase owner (dph_own, dph_vld) on each accepted transfer; S_HWDATA SHALL be muxed by dph_own.
REQ-015 SHALL broadcast S_HRDATA to both masters and route S_HREADY/S_HRESP only to dph_own; the other master SHALL see HRESP=0 and HREADY per REQ-013 or 1.
REQ-016 SHALL pass the two-cycle ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) unmodified to dph_own.
REQ-017 SHALL, when both masters request at an idle boundary, resolve the tie per REQ-022; the loser is captured per REQ-012 at zero extra slave latency.
REQ-018 SHALL drive S_HTRANS=IDLE and S_HSEL=0 when no master requests.

Reset
REQ-019 SHALL, on RESET=1, clear pend, dph_vld and hold registers, set last_grant=M1, and force all S_ outputs to 0 (HTRANS=IDLE) and M*_HREADY=1, M*_HRESP=0, M*_HRDATA=0.
REQ-020 SHALL abandon any transfer in flight on reset mid-operation; no captured transfer SHALL be replayed after reset.

Configuration
REQ-021 SHALL use macro AHB_ARB_RR_EN to select the tie-break policy.
REQ-022 SHALL, with AHB_ARB_RR_EN defined, grant ties to the master not equal to last_grant; without it, SHALL grant ties to M0 (fixed priority) and SHALL NOT implement last_grant.

Structure
REQ-023 SHALL place the HTRANS/HSIZE/HBURST encodings and an address-phase struct typedef (addr, trans, write, size, burst, prot, lock) in shared package ahb_arb_pkg.
REQ-024 SHALL implement the per-master capture register, pend flag and HREADY stall in sub-module ahb_arb_hold, instantiated twice.

Verification
REQ-025 SHALL cover: M0 single write to 0x8000 with M1 idle -> S_HADDR=0x8000 same cycle, M0_HREADY mirrors S_HREADY, M1_HREADY=1.
REQ-026 SHALL cover: M0 and M1 both NONSEQ in the same cycle, no macro -> M0 granted, M1 captured, M1_HREADY=0 until its data phase completes, M1 transfer on slave the next boundary.
REQ-027 SHALL cover: same as REQ-026 with AHB_ARB_RR_EN and last_grant=M0 -> M1 granted first.
REQ-028 SHALL cover: M0 INCR4 burst with M1 NONSEQ at beat 2 -> all four M0 beats contiguous on slave, M1 follows immediately after.
REQ-029 SHALL cover: slave ERROR on M1 read -> M1_HRESP=1 for two cycles, M0_HRESP=0 throughout.
REQ-030 SHALL cover: RESET asserted while M1 is pending -> next cycle pend=0, S_HTRANS=IDLE, both HREADY=1.
